// File: rtl/addsub_cla_pipe_pkg.sv
// Shared mode encodings and stage-count helper for the pipelined CLA add/sub.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int num_stages(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

endpackage

// File: rtl/addsub_cla_pipe_cla_segment.sv
// Combinational N-bit carry-lookahead segment built from 4-bit lookahead blocks.
// Exposes segment generate/propagate so callers can look ahead across segments.
module cla_segment
  import addsub_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         g,
  output logic         p
);

  localparam int NB = (N + 3) / 4;
  localparam int NP = NB * 4;

  logic [NP-1:0] gen;
  logic [NP-1:0] prop;
  logic [NP-1:0] cy;
  logic [NB:0]   blk_c;
  logic [NB-1:0] blk_g;
  logic [NB-1:0] blk_p;
  logic          unused_pad;

  // Padding bits propagate, so the top block carry equals the carry out of bit N-1.
  always_comb begin
    gen         = {NP{1'b0}};
    prop        = {NP{1'b1}};
    gen[N-1:0]  = a & b;
    prop[N-1:0] = a ^ b;
  end

  assign blk_c[0] = c_in;

  for (genvar j = 0; j < NB; j++) begin : g_blk
    localparam int B = 4 * j;
    assign cy[B]   = blk_c[j];
    assign cy[B+1] = gen[B] | (prop[B] & blk_c[j]);
    assign cy[B+2] = gen[B+1] | (prop[B+1] & gen[B]) | (prop[B+1] & prop[B] & blk_c[j]);
    assign cy[B+3] = gen[B+2] | (prop[B+2] & gen[B+1]) | (prop[B+2] & prop[B+1] & gen[B])
                   | (prop[B+2] & prop[B+1] & prop[B] & blk_c[j]);
    assign blk_g[j] = gen[B+3] | (prop[B+3] & gen[B+2]) | (prop[B+3] & prop[B+2] & gen[B+1])
                    | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B]);
    assign blk_p[j]   = &prop[B +: 4];
    assign blk_c[j+1] = blk_g[j] | (blk_p[j] & blk_c[j]);
  end

  // Fold block generate/propagate into the segment-level pair.
  always_comb begin
    g = 1'b0;
    p = 1'b1;
    for (int j = 0; j < NB; j++) begin
      g = blk_g[j] | (blk_p[j] & g);
      p = p & blk_p[j];
    end
  end

  assign s          = prop[N-1:0] ^ cy[N-1:0];
  assign c_out      = blk_c[NB];
  assign unused_pad = ^cy;

endmodule

// File: rtl/addsub_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one SEG-bit segment resolved per stage.
// Define ADDSUB_CLA_PIPE_OVF_EN to build the signed overflow flag; otherwise it reads 0.
module addsub_cla_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 257,
  parameter int SEG   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             add_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry_out,
  output logic             overflow
);

  localparam int STAGES = num_stages(WIDTH, SEG);

  logic             adv;
  logic             stg_valid [STAGES];
  logic             stg_carry [STAGES];
  logic             stg_mode  [STAGES];
  logic [WIDTH-1:0] stg_a     [STAGES];
  logic [WIDTH-1:0] stg_b     [STAGES];
  logic [WIDTH-1:0] stg_res   [STAGES];
  logic             unused_tail;

  assign adv         = ~stg_valid[STAGES-1] | out_ready;
  assign in_ready    = adv;
  assign out_valid   = stg_valid[STAGES-1];
  assign s           = stg_res[STAGES-1];
  assign carry_out   = stg_carry[STAGES-1];
  assign unused_tail = ^{stg_mode[STAGES-1], stg_a[STAGES-1], stg_b[STAGES-1]};

`ifdef ADDSUB_CLA_PIPE_OVF_EN
  logic ovf;
  assign overflow = ovf;
`else
  assign overflow = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int N  = (k == STAGES - 1) ? WIDTH - LO : SEG;

    logic             v_in;
    logic             c_in;
    logic             m_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] r_next;
    logic [N-1:0]     seg_s;
    logic             seg_c;
    logic             seg_g;
    logic             seg_p;
    logic             unused_gp;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign m_in = add_sub;
      assign c_in = (add_sub == SUB);
      assign a_in = a;
      assign b_in = (add_sub == ADD) ? b : ~b;
      assign r_in = {WIDTH{1'b0}};
    end else begin : g_link
      assign v_in = stg_valid[k-1];
      assign m_in = stg_mode[k-1];
      assign c_in = stg_carry[k-1];
      assign a_in = stg_a[k-1];
      assign b_in = stg_b[k-1];
      assign r_in = stg_res[k-1];
    end

    cla_segment #(.N(N)) u_seg (
      .a     (a_in[LO +: N]),
      .b     (b_in[LO +: N]),
      .c_in  (c_in),
      .s     (seg_s),
      .c_out (seg_c),
      .g     (seg_g),
      .p     (seg_p)
    );

    assign unused_gp = seg_g ^ seg_p;

    // Splice this stage's resolved segment into the result carried forward.
    always_comb begin
      r_next          = r_in;
      r_next[LO +: N] = seg_s;
    end

    // Stage register: shifts on global advance, holds while the output is stalled.
    always_ff @(posedge clk) begin
      if (rst) begin
        stg_valid[k] <= 1'b0;
        stg_carry[k] <= 1'b0;
        stg_mode[k]  <= 1'b0;
        stg_a[k]     <= {WIDTH{1'b0}};
        stg_b[k]     <= {WIDTH{1'b0}};
        stg_res[k]   <= {WIDTH{1'b0}};
      end else if (adv) begin
        stg_valid[k] <= v_in;
        stg_carry[k] <= (k == STAGES - 1) ? (seg_c ^ m_in) : seg_c;
        stg_mode[k]  <= m_in;
        stg_a[k]     <= a_in;
        stg_b[k]     <= b_in;
        stg_res[k]   <= r_next;
      end
    end

`ifdef ADDSUB_CLA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf <= 1'b0;
        end else if (adv) begin
          ovf <= seg_s[N-1] ^ a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ seg_c;
        end
      end
    end
`endif
  end

endmodule
